// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader: shifts a bit stream into the instruction register and writes words to program memory
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              load_req_i,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    input  logic              load_end_i,
    output logic              sr_in_o,
    output logic              sr_en_o,
    input  logic [15:0]       sr_word_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic [3:0]        bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   word_count;
    logic              err;
    logic              end_pend;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
            end_pend   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (load_req_i) begin
                        state      <= S_LOAD;
                        bit_cnt    <= 4'd0;
                        addr       <= '0;
                        word_count <= '0;
                        err        <= 1'b0;
                        end_pend   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // A bit arriving with load_end_i is consumed before the end is judged
                    if (bit_valid_i) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state <= S_WRITE;
                            if (load_end_i) end_pend <= 1'b1;
                        end else if (load_end_i) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (load_end_i) begin
                        state <= S_DONE;
                        if (bit_cnt != 4'd0) err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (bit_valid_i) err <= 1'b1;
                    if (load_end_i) end_pend <= 1'b1;
                    if (mem_ack_i) begin
                        // The last address is held so a full memory never wraps onto word 0
                        if (addr != ADDR_MAX) addr <= addr + ADDR_W'(1);
                        if (word_count != WC_MAX) word_count <= word_count + (ADDR_W+1)'(1);
                        if (end_pend || load_end_i || addr == ADDR_MAX) state <= S_DONE;
                        else                                            state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign sr_in_o      = bit_i;
    assign sr_en_o      = (state == S_LOAD) && bit_valid_i;
    assign mem_we_o     = (state == S_WRITE);
    assign mem_addr_o   = addr;
    assign mem_wdata_o  = sr_word_i;
    assign busy_o       = (state == S_LOAD) || (state == S_WRITE);
    assign cpu_hold_o   = busy_o;
    assign done_o       = (state == S_DONE);
    assign err_o        = err;
    assign word_count_o = word_count;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a shift register and memory alongside
module tb_prog_loader;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic          clk = 1'b0;
    logic          resetb;
    logic          load_req_i, bit_i, bit_valid_i, load_end_i;
    logic          sr_in_o, sr_en_o;
    logic [15:0]   sr_word_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [15:0]   mem_wdata_o;
    logic          mem_ack_i;
    logic          cpu_hold_o, busy_o, done_o, err_o;
    logic [AW:0]   word_count_o;

    int vecs = 0;
    int errs = 0;
    int ack_lat = 0;
    int we_run = 0;
    int we_hi = 0;
    int en_cnt = 0;
    int wr_addr[$];
    logic [15:0] wr_data[$];
    logic [15:0] wq[$];
    logic        bits[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .resetb(resetb), .load_req_i(load_req_i), .bit_i(bit_i),
        .bit_valid_i(bit_valid_i), .load_end_i(load_end_i), .sr_in_o(sr_in_o),
        .sr_en_o(sr_en_o), .sr_word_i(sr_word_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .word_count_o(word_count_o)
    );

    // The external 16-bit instruction shift register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)      sr_word_i <= 16'h0;
        else if (sr_en_o) sr_word_i <= {sr_word_i[14:0], sr_in_o};
    end

    // One clock cycle, entered and left at a falling edge
    task automatic cycle(input logic bv, input logic b, input logic le, input logic lr);
        bit_valid_i = bv; bit_i = b; load_end_i = le; load_req_i = lr;
        mem_ack_i = mem_we_o && (we_run == ack_lat);
        #1;
        vecs++;
        if (sr_in_o !== b) begin
            errs++; $display("FAIL sr_in: got %b expected %b", sr_in_o, b);
        end
        if (mem_we_o) begin we_run++; we_hi++; end else we_run = 0;
        if (sr_en_o) en_cnt++;
        if (mem_we_o && mem_ack_i) begin
            wr_addr.push_back(int'(mem_addr_o));
            wr_data.push_back(mem_wdata_o);
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete();
        we_hi = 0; en_cnt = 0; we_run = 0;
    endtask

    // Streams wq plus p random trailing bits and checks the outcome against chunking rules
    task automatic run_load(input int p, input bit end_with, input bit gaps, input bit force_all,
                            input int lat, input string tag);
        int nw, nwr, idx, budget, w, exp_en, exp_addr;
        bit exp_err;
        logic le;
        nw = wq.size();
        bits.delete();
        foreach (wq[i]) for (int b = 15; b >= 0; b--) bits.push_back(wq[i][b]);
        for (int i = 0; i < p; i++) bits.push_back(1'($urandom_range(1)));
        clear_logs();
        ack_lat = lat;
        cycle(0, 0, 0, 1);
        vecs++;
        if (busy_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
            errs++; $display("FAIL %s start: busy %b hold %b expected 1 1", tag, busy_o, cpu_hold_o);
        end
        idx = 0; budget = 0;
        while (idx < bits.size() && (force_all || !done_o) && budget < 3000) begin
            budget++;
            if (mem_we_o) cycle(0, 0, 0, 0);
            else if (gaps && $urandom_range(3) == 0) cycle(0, 0, 0, 0);
            else begin
                le = end_with && (idx == bits.size() - 1);
                cycle(1, bits[idx], le, 0);
                idx++;
                if (idx % 16 == 0 && idx / 16 <= CAP) begin
                    vecs++;
                    if (mem_we_o !== 1'b1) begin
                        errs++; $display("FAIL %s we_latency: word %0d we %b expected 1", tag, idx / 16, mem_we_o);
                    end
                end
            end
        end
        vecs++;
        if (budget >= 3000) begin
            errs++; $display("FAIL %s stream_timeout: sent %0d of %0d bits", tag, idx, bits.size());
        end
        w = 0;
        while (mem_we_o && w < 200) begin cycle(0, 0, 0, 0); w++; end
        if (!done_o && !end_with) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);

        nwr      = (nw < CAP) ? nw : CAP;
        exp_err  = (nw < CAP) && (p != 0);
        exp_en   = (nw < CAP) ? bits.size() : CAP * 16;
        exp_addr = (nwr == CAP) ? CAP - 1 : nwr;
        vecs++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
            errs++; $display("FAIL %s end_state: done %b busy %b hold %b expected 1 0 0", tag, done_o, busy_o, cpu_hold_o);
        end
        vecs++;
        if (err_o !== exp_err) begin
            errs++; $display("FAIL %s err: got %b expected %b", tag, err_o, exp_err);
        end
        vecs++;
        if (word_count_o !== (AW+1)'(nwr)) begin
            errs++; $display("FAIL %s word_count: got %0d expected %0d", tag, word_count_o, nwr);
        end
        vecs++;
        if (mem_addr_o !== AW'(exp_addr)) begin
            errs++; $display("FAIL %s addr: got %0d expected %0d", tag, mem_addr_o, exp_addr);
        end
        vecs++;
        if (en_cnt != exp_en) begin
            errs++; $display("FAIL %s shifted_bits: got %0d expected %0d", tag, en_cnt, exp_en);
        end
        vecs++;
        if (wr_addr.size() != nwr) begin
            errs++; $display("FAIL %s writes: got %0d expected %0d", tag, wr_addr.size(), nwr);
        end else begin
            for (int i = 0; i < nwr; i++) begin
                vecs++;
                if (wr_addr[i] != i || wr_data[i] !== wq[i]) begin
                    errs++; $display("FAIL %s write%0d: got @%0d=%h expected @%0d=%h", tag, i, wr_addr[i], wr_data[i], i, wq[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        vecs++;
        if ({sr_in_o, sr_en_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, busy_o, done_o, err_o, word_count_o} !== '0) begin
            errs++; $display("FAIL reset_outputs: we %b addr %0d wdata %h hold %b busy %b done %b err %b wc %0d expected all 0",
                             mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o, busy_o, done_o, err_o, word_count_o);
        end
    endtask

    task automatic test_two_words();
        wq = '{16'hA5C3, 16'h1234};
        run_load(0, 0, 0, 0, 0, "two_words");
    endtask

    task automatic test_ack_stall();
        logic [15:0] w;
        int k, en0;
        w = 16'($urandom);
        clear_logs();
        ack_lat = 5;
        cycle(0, 0, 0, 1);
        for (int b = 15; b >= 0; b--) cycle(1, w[b], 0, 0);
        en0 = en_cnt;
        k = 0;
        while (mem_we_o && k < 50) begin
            cycle(k < 3, 1'($urandom_range(1)), 0, k == 1);
            k++;
        end
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        vecs++;
        if (we_hi != 6) begin
            errs++; $display("FAIL stall we_cycles: got %0d expected 6", we_hi);
        end
        vecs++;
        if (en_cnt != en0) begin
            errs++; $display("FAIL stall sr_en: got %0d shifts during write expected 0", en_cnt - en0);
        end
        vecs++;
        if (wr_data.size() != 1 || wr_data[0] !== w || wr_addr[0] != 0) begin
            errs++; $display("FAIL stall write: got %0d writes first %h expected 1 write %h", wr_data.size(),
                             (wr_data.size() > 0) ? wr_data[0] : 16'h0, w);
        end
        vecs++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || word_count_o !== 3'd1) begin
            errs++; $display("FAIL stall end: err %b done %b wc %0d expected 1 1 1", err_o, done_o, word_count_o);
        end
    endtask

    task automatic test_end_with_last_bit();
        wq = '{16'($urandom)};
        run_load(0, 1, 0, 0, 1, "end_on_16th");
    endtask

    task automatic test_partial_end();
        wq = {};
        run_load(7, 0, 0, 0, 0, "partial_7");
        vecs++;
        if (we_hi != 0) begin
            errs++; $display("FAIL partial_7 we_pulse: got %0d we cycles expected 0", we_hi);
        end
    endtask

    task automatic test_full();
        wq = {};
        for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
        run_load(0, 0, 0, 1, 0, "full");
    endtask

    task automatic test_reset_in_write();
        logic [15:0] w;
        w = 16'($urandom);
        clear_logs();
        ack_lat = 1000;
        cycle(0, 0, 0, 1);
        for (int b = 15; b >= 0; b--) cycle(1, w[b], 0, 0);
        cycle(0, 0, 0, 0);
        vecs++;
        if (mem_we_o !== 1'b1) begin
            errs++; $display("FAIL rst_write pre: we %b expected 1", mem_we_o);
        end
        resetb = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        wq = '{16'($urandom)};
        run_load(0, 0, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        int nw, p;
        for (int t = 0; t < 10; t++) begin
            nw = $urandom_range(6, 1);
            p  = ($urandom_range(1) == 1) ? $urandom_range(15, 1) : 0;
            wq = {};
            for (int i = 0; i < nw; i++) wq.push_back(16'($urandom));
            run_load(p, 1'($urandom_range(1)), 1, 0, $urandom_range(3), "random");
        end
    endtask

    initial begin
        resetb = 1'b0;
        load_req_i = 0; bit_i = 0; bit_valid_i = 0; load_end_i = 0; mem_ack_i = 0;
        repeat (2) @(negedge clk);
        test_reset();
        resetb = 1'b1;
        @(negedge clk);
        test_two_words();
        test_ack_stall();
        test_end_with_last_bit();
        test_partial_end();
        test_full();
        test_reset_in_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
